vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

- Generates 640x480 @ 60 Hz VGA raster timing for the Pong display.
- Sits directly upstream of the pixel-drawing comparators (range and offset checks for paddles and ball), feeding them the current `row`/`col` beam position.
- Drives the monitor sync pins and provides the blanking and frame markers used by game-state update logic.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `CLK_DIV`, 2, system clocks per pixel (≥1)

Ports:
- `clock`  in  1  system clock; one clock domain
- `reset`  in  1  synchronous, active-high reset
- `col`  out  10  horizontal pixel count, 0..H_TOTAL-1
- `row`  out  10  vertical line count, 0..V_TOTAL-1
- `HS`  out  1  horizontal sync, active-low
- `VS`  out  1  vertical sync, active-low
- `blank`  out  1  high outside the visible area, on either axis
- `vblank`  out  1  high when `row` ≥ V_VISIBLE
- `pix_en`  out  1  one-clock strobe: pixel advances on this clock edge
- `frame_end`  out  1  one-clock pulse on the last pixel of the frame
- `frame_cnt`  out  8  frame counter (only with `VGA_FRAME_CNT_EN`)

## Operation
- Definitions:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Divider:
  - `div` counts 0..CLK_DIV-1 and wraps.
  - `pix_en` = (`div` == CLK_DIV-1).
  - With CLK_DIV=1, `pix_en` is constantly high.
- Horizontal counter: on `pix_en`, `col` increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter: `row` increments only when `pix_en` and `col` == H_TOTAL-1; at V_TOTAL-1 it wraps to 0.
- `HS` is low for `col` in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], i.e. 656..751.
- `VS` is low for `row` in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1], i.e. 490..491.
- `blank` = (`col` ≥ H_VISIBLE) | (`row` ≥ V_VISIBLE).
- `frame_end` = `pix_en` & `col`==H_TOTAL-1 & `row`==V_TOTAL-1.
- Arithmetic:
  - All counters are unsigned with no overflow beyond the terminal value; wrap is by explicit compare, not modulo width.
  - Counter widths come from package constants.
- Reset:
  - `div`, `col`, `row` (and `frame_cnt`) go to 0.
  - Resulting outputs: `HS`=1, `VS`=1, `blank`=0, `vblank`=0, `pix_en`=(CLK_DIV==1), `frame_end`=0.
  - Reset mid-frame abandons the frame immediately, with no completion of the current line.
- No state machine is needed beyond the three counters; the axis counters act as the sequencing state.

## Timing
- `col`/`row` are registered.
- `HS`, `VS`, `blank`, `vblank`, `frame_end` are combinational decodes of the same registers, so every output is aligned to the same pixel with zero added latency.
- Consumers registering pixel colour add their own 1-pixel delay and must delay `HS`/`VS` to match; that delay is not done here.
- First `col` increment occurs on the CLK_DIV-th rising edge after `reset` deasserts.
- Frame length: H_TOTAL·V_TOTAL·CLK_DIV clocks (840,000 at defaults).
- Simultaneous wraps: at `col`=799, `row`=524 with `pix_en`, both wrap to 0 on the same edge and `frame_end` is high for exactly that one clock.
- `reset` overrides `pix_en` on the same edge.

## Configuration
- `VGA_FRAME_CNT_EN`:
  - Defined: `frame_cnt` port exists; it increments by 1 on every `frame_end` edge, wraps 255→0, and resets to 0. Used to pace ball speed.
  - Undefined: port and register are absent; all other behaviour is identical.

## Structure
- Package `vga_pkg`:
  - default timing constants;
  - `H_TOTAL`, `V_TOTAL`;
  - `COORD_W`=10;
  - typedef `coord_t` (logic [COORD_W-1:0]) shared with the drawing comparators.
- One sub-module, `vga_axis_counter`:
  - parameterised by visible/fp/sync/bp;
  - inputs `clock`, `reset`, `inc`;
  - outputs `count`, `sync_n`, `active`, `at_end`.
- Instantiated twice:
  - horizontal: `inc`=`pix_en`;
  - vertical: `inc`=`pix_en`&h.`at_end`.

## Test plan
- Reset then release, CLK_DIV=2 → `col` stays 0 for 1 clock, becomes 1 on the 2nd edge; `HS`=`VS`=1, `blank`=0.
- Run one line → `HS` low exactly 192 clocks (`col` 656..751); `blank` rises at `col`=640; `row` increments to 1 as `col` wraps 799→0.
- Run a full frame → `VS` low for 2 lines (`row` 490..491); `frame_end` pulses once, 840,000 clocks after reset release minus 1; `row`,`col` both return to 0 on the next edge.
- Assert `reset` at `row`=300, `col`=400 for one clock → next cycle `row`=`col`=0, `HS`=1, no `frame_end`.
- CLK_DIV=1 build → `pix_en` constant 1, line period 800 clocks.
- With `VGA_FRAME_CNT_EN`, run 257 frames → `frame_cnt` reads 1 (wrapped).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA raster constants and the beam coordinate type used by the drawing comparators.
package vga_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;
  localparam int unsigned CLK_DIV_DEF   = 2;

  localparam int unsigned H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned FCNT_W  = 8;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync, active-area and terminal-count decodes.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned VISIBLE = 640,
  parameter int unsigned FP      = 16,
  parameter int unsigned SYNC    = 96,
  parameter int unsigned BP      = 48
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inc,
  output logic [COORD_W-1:0] count,
  output logic               sync_n,
  output logic               active,
  output logic               at_end
);

  localparam int unsigned TOTAL      = VISIBLE + FP + SYNC + BP;
  localparam coord_t      LAST       = coord_t'(TOTAL - 1);
  localparam coord_t      VIS_END    = coord_t'(VISIBLE);
  localparam coord_t      SYNC_FIRST = coord_t'(VISIBLE + FP);
  localparam coord_t      SYNC_LAST  = coord_t'(VISIBLE + FP + SYNC - 1);

  coord_t count_q, count_d;

  // Wrap by explicit compare against the terminal value, never by width overflow.
  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = (count_q == LAST) ? '0 : count_q + coord_t'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_end = (count_q == LAST);
  assign active = (count_q < VIS_END);
  assign sync_n = !((count_q >= SYNC_FIRST) && (count_q <= SYNC_LAST));

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA raster timing generator: pixel divider, col/row counters and sync/blank decodes.
// Optional VGA_FRAME_CNT_EN adds an 8-bit frame counter output.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter int unsigned CLK_DIV   = CLK_DIV_DEF
) (
  input  logic               clock,
  input  logic               reset,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               HS,
  output logic               VS,
  output logic               blank,
  output logic               vblank,
  output logic               pix_en,
  output logic               frame_end
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FCNT_W-1:0]  frame_cnt
`endif
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             h_active, v_active, h_at_end, v_at_end, v_inc;

  // With CLK_DIV=1 the divider never leaves 0, so pix_en is held high.
  assign pix_en = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (pix_en) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign v_inc = pix_en & h_at_end;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clock  (clock),
    .reset  (reset),
    .inc    (pix_en),
    .count  (col),
    .sync_n (HS),
    .active (h_active),
    .at_end (h_at_end)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clock  (clock),
    .reset  (reset),
    .inc    (v_inc),
    .count  (row),
    .sync_n (VS),
    .active (v_active),
    .at_end (v_at_end)
  );

  assign vblank    = !v_active;
  assign blank     = !h_active | !v_active;
  assign frame_end = pix_en & h_at_end & v_at_end;

`ifdef VGA_FRAME_CNT_EN
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_end) begin
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using a shrunken raster (15 x 8, sync at col 10..12 / row 5..6).
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] row;
    logic [9:0] col;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       vblank;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] col, row, col1, row1;
  logic       hs, vs, blank, vblank, pix_en, frame_end;
  logic       hs1, vs1, blank1, vblank1, pix_en1, frame_end1;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt, frame_cnt1;
`endif

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(2)
  ) u_dut (
    .clock(clk), .reset(rst), .col(col), .row(row), .HS(hs), .VS(vs),
    .blank(blank), .vblank(vblank), .pix_en(pix_en), .frame_end(frame_end)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  vga_sync_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(1)
  ) u_dut1 (
    .clock(clk), .reset(rst), .col(col1), .row(row1), .HS(hs1), .VS(vs1),
    .blank(blank1), .vblank(vblank1), .pix_en(pix_en1), .frame_end(frame_end1)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(frame_cnt1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Raster order from (0,0); windows written out by hand for the 15x8 raster.
  task automatic push_pixels(input int npix);
    int k = 0;
    for (int f = 0; f < 2 && k < npix; f++)
      for (int r = 0; r < 8 && k < npix; r++)
        for (int c = 0; c < 15 && k < npix; c++) begin
          exp_t e;
          e.row    = 10'(r);
          e.col    = 10'(c);
          e.hs     = !(c >= 10 && c <= 12);
          e.vs     = !(r == 5 || r == 6);
          e.blank  = (c >= 8) || (r >= 4);
          e.vblank = (r >= 4);
          e.fe     = (r == 7) && (c == 14);
          exp_q.push_back(e);
          k++;
        end
  endtask

  // Monitor: each pix_en strobe presents one pixel to the scoreboard.
  always @(negedge clk) begin
    if (pix_en && exp_q.size() != 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = {row, col, hs, vs, blank, vblank, frame_end};
      chk("sb_pixel", 32'(a), 32'(e));
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int cyc, hs_lo, vs_lo, n, p0, fe_cnt;
    logic fe_seen;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_col",     32'(col),       32'd0);
    chk("rst_row",     32'(row),       32'd0);
    chk("rst_hs",      32'(hs),        32'd1);
    chk("rst_vs",      32'(vs),        32'd1);
    chk("rst_blank",   32'(blank),     32'd0);
    chk("rst_vblank",  32'(vblank),    32'd0);
    chk("rst_pix_en",  32'(pix_en),    32'd0);
    chk("rst_fe",      32'(frame_end), 32'd0);
    chk("rst_pix_en1", 32'(pix_en1),   32'd1);
`ifdef VGA_FRAME_CNT_EN
    chk("rst_fcnt",    32'(frame_cnt), 32'd0);
`endif

    // One full frame plus three pixels into the next.
    push_pixels(123);
    rst = 1'b0;
    cyc = 0; hs_lo = 0; vs_lo = 0; fe_seen = 1'b0;
    while (!fe_seen && cyc < 1000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (!hs) hs_lo++;
      if (!vs) vs_lo++;
      if (cyc == 1) chk("col_hold_1st_edge", 32'(col), 32'd0);
      if (cyc == 2) chk("col_inc_2nd_edge",  32'(col), 32'd1);
      if (frame_end) fe_seen = 1'b1;
    end
    chk("frame_end_clks", 32'(cyc),   32'd239);
    chk("hs_low_clks",    32'(hs_lo), 32'd48);
    chk("vs_low_clks",    32'(vs_lo), 32'd60);
    @(posedge clk);
    @(negedge clk);
    chk("wrap_col", 32'(col),       32'd0);
    chk("wrap_row", 32'(row),       32'd0);
    chk("wrap_fe",  32'(frame_end), 32'd0);
    wait_drain("sb_drain_frame");

    // CLK_DIV=1: pix_en never drops and a line lasts 15 clocks.
    n = 0;
    while (col1 != 10'd0 && n < 40) begin @(negedge clk); n++; end
    n = 0; p0 = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!pix_en1) p0++;
    end while (col1 != 10'd0 && n < 40);
    chk("div1_line_clks",  32'(n),  32'd15);
    chk("div1_pix_en_low", 32'(p0), 32'd0);

    // Mid-frame reset for one clock.
    n = 0;
    while (!(row == 10'd5 && col == 10'd9) && n < 600) begin @(negedge clk); n++; end
    chk("reach_r5_c9", 32'(row == 10'd5 && col == 10'd9), 32'd1);
    rst = 1'b1;
    push_pixels(20);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_col",   32'(col),       32'd0);
    chk("midrst_row",   32'(row),       32'd0);
    chk("midrst_hs",    32'(hs),        32'd1);
    chk("midrst_fe",    32'(frame_end), 32'd0);
    chk("midrst_blank", 32'(blank),     32'd0);
    rst = 1'b0;
    wait_drain("sb_drain_restart");

`ifdef VGA_FRAME_CNT_EN
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("fcnt_reset", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    fe_cnt = 0; n = 0;
    while (fe_cnt < 257 && n < 70000) begin
      @(negedge clk);
      n++;
      if (frame_end) fe_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    chk("fcnt_257_frames", 32'(frame_cnt), 32'd1);
`else
    fe_cnt = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
